// File: rtl/rx_sink_if.sv
// Valid/ready word link plus the show-ahead read side of the receive sink.
// The slave modport is the sink's view; master is the transmitter/reader view.
interface rx_sink_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 8
);
    logic             valid_i;
    logic [N-1:0]     data_i;
    logic             ready_o;
    logic             rd_en_i;
    logic             rd_valid_o;
    logic [N-1:0]     rd_data_o;
    logic             full_o;
    logic             empty_o;
    logic [CNT_W-1:0] rx_count_o;
    logic             err_o;

    modport master (
        output valid_i, data_i, rd_en_i,
        input  ready_o, rd_valid_o, rd_data_o, full_o, empty_o, rx_count_o, err_o
    );

    modport slave (
        input  valid_i, data_i, rd_en_i,
        output ready_o, rd_valid_o, rd_data_o, full_o, empty_o, rx_count_o, err_o
    );
endinterface

// File: rtl/rx_sink.sv
// Link receive terminator: buffers accepted words in a show-ahead FIFO, counts
// them with a saturating counter and flags any word that differs from EXP_DATA.
module rx_sink #(
    parameter int unsigned  N        = 4,
    parameter int unsigned  DEPTH    = 4,
    parameter logic [N-1:0] EXP_DATA = 4'b0101,
    parameter int unsigned  CNT_W    = 8
) (
    input logic      clk,
    input logic      rst,
    rx_sink_if.slave bus
);
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LVL_LAST = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] LVL_ZERO = (AW + 1)'(0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RX   = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [N-1:0]     mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             ready_s;
    logic             push_s;
    logic             pop_s;

    // ready is a pure state decode so it never loops back through valid_i/rd_en_i
    assign ready_s = (state_q == ST_RX);
    assign push_s  = bus.valid_i & ready_s;
    assign pop_s   = bus.rd_en_i & (level_q != LVL_ZERO);

    assign bus.ready_o    = ready_s;
    assign bus.rd_valid_o = (level_q != LVL_ZERO);
    assign bus.rd_data_o  = (level_q != LVL_ZERO) ? mem_q[rd_ptr_q] : {N{1'b0}};
    assign bus.full_o     = (level_q == LVL_FULL);
    assign bus.empty_o    = (level_q == LVL_ZERO);
    assign bus.rx_count_o = cnt_q;
    assign bus.err_o      = err_q;

    // Next-state logic for the link FSM
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = ST_RX;
            ST_RX: begin
                if (push_s && !pop_s && (level_q == LVL_LAST)) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_RX;
                end
            end
            ST_FULL: begin
                if (pop_s) begin
                    state_d = ST_RX;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pointer, fill-level, counter and error-flag next values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
            if (bus.data_i != EXP_DATA) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            level_d = level_q + LVL_ONE;
        end else if (pop_s && !push_s) begin
            level_d = level_q - LVL_ONE;
        end else begin
            level_d = level_q;
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= LVL_ZERO;
            cnt_q    <= {CNT_W{1'b0}};
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // FIFO storage; cleared on reset so no stale word can ever surface
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {N{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= bus.data_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end
endmodule

// File: tb/tb_rx_sink.sv
// Randomised scoreboard bench for rx_sink: two instances (8-bit and 3-bit counter)
// share one stimulus stream and are checked against a queue-based link model.
module tb_rx_sink;
    localparam int         N     = 4;
    localparam int         DEPTH = 4;
    localparam int         CNT_A = 8;
    localparam int         CNT_B = 3;
    localparam logic [3:0] EXP   = 4'b0101;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rx_sink_if #(.N(N), .CNT_W(CNT_A)) bus_a ();
    rx_sink_if #(.N(N), .CNT_W(CNT_B)) bus_b ();

    assign bus_b.valid_i = bus_a.valid_i;
    assign bus_b.data_i  = bus_a.data_i;
    assign bus_b.rd_en_i = bus_a.rd_en_i;

    rx_sink #(.N(N), .DEPTH(DEPTH), .EXP_DATA(EXP), .CNT_W(CNT_A)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a));
    rx_sink #(.N(N), .DEPTH(DEPTH), .EXP_DATA(EXP), .CNT_W(CNT_B)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b));

    // Reference model: buffered words as a queue, plain integers for the rest
    logic [3:0] exp_q[$];
    int  m_level  = 0;
    int  m_cnt    = 0;
    bit  m_err    = 1'b0;
    bit  m_dead   = 1'b1;
    bit  m_ready  = 1'b0;
    bit  model_ok = 1'b0;
    int  n_checks = 0;
    int  n_fail   = 0;

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit push, pop;
        if (rst) begin
            exp_q.delete();
            m_level = 0;
            m_cnt   = 0;
            m_err   = 1'b0;
            m_dead  = 1'b1;
        end else begin
            push = bus_a.valid_i && m_ready;
            pop  = bus_a.rd_en_i && (m_level > 0);
            if (push) begin
                exp_q.push_back(bus_a.data_i);
                m_cnt++;
                if (bus_a.data_i != EXP) m_err = 1'b1;
            end
            m_level = m_level + int'(push) - int'(pop);
            m_dead  = 1'b0;
        end
        m_ready  = !m_dead && (m_level < DEPTH);
        model_ok = 1'b1;
    endtask

    task automatic cyc(input logic r, input logic v, input logic [3:0] d, input logic re);
        rst           = r;
        bus_a.valid_i = v;
        bus_a.data_i  = d;
        bus_a.rd_en_i = re;
        @(posedge clk);
        #1;
        model_edge();
    endtask

    // Monitor: compares every output on the falling edge and retires popped words
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                check("ready_a", 32'(bus_a.ready_o), 32'(m_ready));
                check("ready_b", 32'(bus_b.ready_o), 32'(m_ready));
                check("full", 32'(bus_a.full_o), 32'(m_level == DEPTH));
                check("empty", 32'(bus_a.empty_o), 32'(m_level == 0));
                check("count_a", 32'(bus_a.rx_count_o), 32'(sat(m_cnt, CNT_A)));
                check("count_b", 32'(bus_b.rx_count_o), 32'(sat(m_cnt, CNT_B)));
                check("err_a", 32'(bus_a.err_o), 32'(m_err));
                check("err_b", 32'(bus_b.err_o), 32'(m_err));
                if (exp_q.size() > 0) begin
                    check("rd_valid", 32'(bus_a.rd_valid_o), 32'd1);
                    check("rd_data_a", 32'(bus_a.rd_data_o), 32'(exp_q[0]));
                    check("rd_data_b", 32'(bus_b.rd_data_o), 32'(exp_q[0]));
                    if (bus_a.rd_en_i && !rst) void'(exp_q.pop_front());
                end else begin
                    check("rd_valid", 32'(bus_a.rd_valid_o), 32'd0);
                    check("rd_data_a", 32'(bus_a.rd_data_o), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed scenarios, then a randomised stream with occasional resets
    initial begin
        rst           = 1'b1;
        bus_a.valid_i = 1'b0;
        bus_a.data_i  = 4'd0;
        bus_a.rd_en_i = 1'b0;

        repeat (2) cyc(1'b1, 1'b0, 4'd0, 1'b0);
        check("dead_ready", 32'(bus_a.ready_o), 32'd0);
        cyc(1'b0, 1'b1, EXP, 1'b0);
        check("first_ready", 32'(bus_a.ready_o), 32'd1);
        cyc(1'b0, 1'b1, EXP, 1'b0);
        check("first_cnt", 32'(bus_a.rx_count_o), 32'd1);
        check("first_data", 32'(bus_a.rd_data_o), 32'(EXP));
        repeat (4) cyc(1'b0, 1'b1, EXP, 1'b0);
        check("fill_full", 32'(bus_a.full_o), 32'd1);
        check("fill_ready", 32'(bus_a.ready_o), 32'd0);
        check("fill_cnt", 32'(bus_a.rx_count_o), 32'd4);
        repeat (5) cyc(1'b0, 1'b0, 4'd0, 1'b1);
        check("drain_empty", 32'(bus_a.empty_o), 32'd1);

        repeat (2) cyc(1'b1, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 4'(i), 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 4'd0, 1'b1);
        check("order_empty", 32'(bus_a.empty_o), 32'd1);
        check("order_cnt", 32'(bus_a.rx_count_o), 32'd4);
        check("order_err", 32'(bus_a.err_o), 32'd1);

        cyc(1'b0, 1'b1, 4'd6, 1'b0);
        cyc(1'b0, 1'b1, 4'd7, 1'b0);
        repeat (10) cyc(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b1);
        check("simul_cnt", 32'(bus_a.rx_count_o), 32'd16);
        check("simul_full", 32'(bus_a.full_o), 32'd0);

        repeat (2) cyc(1'b0, 1'b1, 4'd9, 1'b0);
        check("rel_full", 32'(bus_a.full_o), 32'd1);
        cyc(1'b0, 1'b1, 4'd10, 1'b1);
        check("rel_ready", 32'(bus_a.ready_o), 32'd1);
        cyc(1'b0, 1'b1, 4'd10, 1'b0);
        check("rel_refull", 32'(bus_a.full_o), 32'd1);

        cyc(1'b1, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 1'b0);
        repeat (9) cyc(1'b0, 1'b1, EXP, 1'b1);
        check("sat_cnt_b", 32'(bus_b.rx_count_o), 32'd7);
        check("sat_cnt_a", 32'(bus_a.rx_count_o), 32'd9);
        repeat (2) cyc(1'b0, 1'b1, EXP, 1'b0);
        cyc(1'b1, 1'b1, EXP, 1'b0);
        check("rst_empty", 32'(bus_a.empty_o), 32'd1);
        check("rst_cnt", 32'(bus_b.rx_count_o), 32'd0);
        check("rst_ready", 32'(bus_a.ready_o), 32'd0);
        cyc(1'b0, 1'b1, EXP, 1'b0);
        check("rst_ready_back", 32'(bus_a.ready_o), 32'd1);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 1) == 0) ? EXP : 4'($urandom_range(0, 15)),
                ($urandom_range(0, 2) == 0));
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
